cpe_muldiv: RTL and testbench
=============================

CPE_MULDIV -- requirements
Module: cpe_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 clk_w_i  input  1  sole clock; all state updates on rising edge.
REQ-003 res_w_i_l  input  1  reset, synchronous, active-low.
REQ-004 start_w_i_h  input  1  request new operation; accepted only in IDLE.
REQ-005 abort_w_i_h  input  1  cancel in-flight operation.
REQ-006 funct3_w_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_w_i  input  XLEN  operand A (multiplicand/dividend).
REQ-008 rs2_w_i  input  XLEN  operand B (multiplier/divisor).
REQ-009 busy_w_o_h  output  1  high whenever state != IDLE.
REQ-010 done_w_o_h  output  1  one-cycle pulse; result_w_o valid in that cycle.
REQ-011 result_w_o  output  XLEN  registered result, held until next completed operation.

Function
REQ-012 States: IDLE, CALC, FIXUP, DONE; encoding free.
REQ-013 IDLE->CALC when start_w_i_h=1; funct3, rs1, rs2 captured on that edge; later input changes have no effect.
REQ-014 Start cycle = T; CALC occupies T+1..T+XLEN (exactly XLEN iterations, step counter 0..XLEN-1); FIXUP at T+XLEN+1; DONE at T+XLEN+2; IDLE at T+XLEN+3.
REQ-015 DONE: done_w_o_h=1, result_w_o updated on entry; DONE->IDLE unconditionally.
REQ-016 start_w_i_h while busy (CALC/FIXUP/DONE) ignored; no queuing.
REQ-017 Multiply: shift-add over operand magnitudes, one multiplier bit per CALC cycle, 2*XLEN-bit product.
REQ-018 Signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned; FIXUP negates product when operand signs differ.
REQ-019 MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
REQ-020 Divide: restoring division over magnitudes, one quotient bit per CALC cycle; DIV/REM signed, DIVU/REMU unsigned.
REQ-021 FIXUP: quotient negated when signs differ; remainder takes dividend sign (truncating toward zero).
REQ-022 Divide by zero (rs2=0), detected on start edge: IDLE->FIXUP at T+1, DONE at T+2; quotient = all ones; remainder = rs1.
REQ-023 Signed overflow (DIV/REM, rs1=-2^(XLEN-1), rs2=-1): same 2-cycle shortcut; quotient = rs1; remainder = 0.
REQ-024 Divide by zero takes precedence over overflow check (only one can apply).
REQ-025 abort_w_i_h=1 in CALC or FIXUP: state->IDLE next edge; no done pulse; result_w_o unchanged.
REQ-026 abort in DONE: ignored, pulse completes; abort in IDLE: no effect; abort and start same cycle in IDLE: start wins.
REQ-027 All arithmetic internal widths XLEN+1 / 2*XLEN; no truncation before final select.

Reset
REQ-028 res_w_i_l=0 on a rising edge: state=IDLE, counter=0, busy_w_o_h=0, done_w_o_h=0, result_w_o=0, operand/accumulator registers=0.
REQ-029 Reset overrides start and abort; reset mid-CALC abandons operation with no done pulse.
REQ-030 First start accepted on first edge with res_w_i_l=1.

Verification (XLEN=32 unless noted)
REQ-031 Reset held 2 cycles mid-CALC -> busy=0, done=0, result=0x00000000 next cycle; no later done pulse.
REQ-032 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly at T+34, busy high T+1..T+34; repeat XLEN=16 -> done at T+18.
REQ-033 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-035 DIVU 0x1234/0 -> 0xFFFFFFFF, done at T+2; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+2; REM -> 0.
REQ-036 abort at T+10 of DIV -> busy=0 at T+11, no done, result keeps prior value; start pulsed at T+5 of another op ignored, that op completes normally at T+34.

Source files
------------

// File: rtl/cpe_muldiv.sv
// cpe_muldiv: iterative integer multiply/divide unit, one operand bit per cycle.
//
// Ports:
//   clk_w_i       - clock, all state changes on the rising edge
//   res_w_i_l     - synchronous active-low reset
//   start_w_i_h   - launch an operation (taken only when idle)
//   abort_w_i_h   - cancel an operation in CALC or FIXUP
//   funct3_w_i    - operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_w_i       - operand A (multiplicand / dividend)
//   rs2_w_i       - operand B (multiplier / divisor)
//   busy_w_o_h    - high while an operation is in progress (incl. DONE)
//   done_w_o_h    - one-cycle completion pulse, result_w_o valid with it
//   result_w_o    - result, held until the next completed operation
module cpe_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_w_i,
    input  logic            res_w_i_l,
    input  logic            start_w_i_h,
    input  logic            abort_w_i_h,
    input  logic [2:0]      funct3_w_i,
    input  logic [XLEN-1:0] rs1_w_i,
    input  logic [XLEN-1:0] rs2_w_i,
    output logic            busy_w_o_h,
    output logic            done_w_o_h,
    output logic [XLEN-1:0] result_w_o
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastStep = CntW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

    state_e            state;
    logic [CntW-1:0]   cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc;       // {upper, lower}: product or {remainder, quotient}
    logic              neg;       // negate product / quotient in FIXUP
    logic              rem_neg;   // remainder takes the dividend sign
    logic              special;   // div-by-zero / overflow result preloaded in acc

    // Operand decode at the start edge
    logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_val;

    always_comb begin
        is_div   = funct3_w_i[2];
        is_rem   = funct3_w_i[1];
        a_signed = funct3_w_i[2] ? ~funct3_w_i[0] : (funct3_w_i[1:0] != 2'b11);
        b_signed = funct3_w_i[2] ? ~funct3_w_i[0] : ~funct3_w_i[1];
        a_neg    = a_signed & rs1_w_i[XLEN-1];
        b_neg    = b_signed & rs2_w_i[XLEN-1];
        a_mag    = a_neg ? -rs1_w_i : rs1_w_i;
        b_mag    = b_neg ? -rs2_w_i : rs2_w_i;
        div_zero = is_div && (rs2_w_i == '0);
        div_ovf  = is_div && !funct3_w_i[0] && (rs2_w_i == '1) &&
                   (rs1_w_i == {1'b1, {(XLEN-1){1'b0}}});
        if (div_zero) begin
            special_val = is_rem ? rs1_w_i : '1;
        end else begin
            special_val = is_rem ? '0 : rs1_w_i;
        end
    end

    // One iteration of shift-add multiply and restoring divide
    logic [XLEN:0]     mul_sum, div_part, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_part = acc[2*XLEN-1:XLEN-1];
        div_diff = div_part - {1'b0, opnd};
        div_ok   = ~div_diff[XLEN];
        div_next = {(div_ok ? div_diff[XLEN-1:0] : div_part[XLEN-1:0]),
                    acc[XLEN-2:0], div_ok};
    end

    // Sign fixup and final select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg ? -acc : acc;
        quo_fix  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (special) begin
            fix_res = acc[XLEN-1:0];
        end else if (op[2]) begin
            fix_res = op[1] ? rem_fix : quo_fix;
        end else if (op == 3'b000) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_w_i) begin
        if (!res_w_i_l) begin
            state      <= StIdle;
            cnt        <= '0;
            op         <= '0;
            opnd       <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            rem_neg    <= 1'b0;
            special    <= 1'b0;
            busy_w_o_h <= 1'b0;
            done_w_o_h <= 1'b0;
            result_w_o <= '0;
        end else begin
            case (state)
                StIdle: begin
                    done_w_o_h <= 1'b0;
                    if (start_w_i_h) begin
                        op         <= funct3_w_i;
                        cnt        <= '0;
                        neg        <= a_neg ^ b_neg;
                        rem_neg    <= a_neg;
                        special    <= div_zero | div_ovf;
                        opnd       <= is_div ? b_mag : a_mag;
                        busy_w_o_h <= 1'b1;
                        if (div_zero || div_ovf) begin
                            acc   <= {{XLEN{1'b0}}, special_val};
                            state <= StFixup;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (abort_w_i_h) begin
                        state      <= StIdle;
                        busy_w_o_h <= 1'b0;
                    end else begin
                        acc <= op[2] ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LastStep) begin
                            state <= StFixup;
                        end
                    end
                end
                StFixup: begin
                    if (abort_w_i_h) begin
                        state      <= StIdle;
                        busy_w_o_h <= 1'b0;
                    end else begin
                        result_w_o <= fix_res;
                        done_w_o_h <= 1'b1;
                        state      <= StDone;
                    end
                end
                default: begin  // StDone: abort is ignored here
                    state      <= StIdle;
                    cnt        <= '0;
                    busy_w_o_h <= 1'b0;
                    done_w_o_h <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpe_muldiv.sv
module tb_cpe_muldiv;

    logic        clk = 1'b0;
    logic        res_l = 1'b0;
    logic        abort = 1'b0;

    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, done;
    logic [31:0] result;

    logic        start16 = 1'b0;
    logic [2:0]  funct3_16 = '0;
    logic [15:0] rs1_16 = '0, rs2_16 = '0;
    logic        busy16, done16;
    logic [15:0] result16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpe_muldiv #(.XLEN(32)) dut (
        .clk_w_i     (clk),
        .res_w_i_l   (res_l),
        .start_w_i_h (start),
        .abort_w_i_h (abort),
        .funct3_w_i  (funct3),
        .rs1_w_i     (rs1),
        .rs2_w_i     (rs2),
        .busy_w_o_h  (busy),
        .done_w_o_h  (done),
        .result_w_o  (result)
    );

    cpe_muldiv #(.XLEN(16)) dut16 (
        .clk_w_i     (clk),
        .res_w_i_l   (res_l),
        .start_w_i_h (start16),
        .abort_w_i_h (abort),
        .funct3_w_i  (funct3_16),
        .rs1_w_i     (rs1_16),
        .rs2_w_i     (rs2_16),
        .busy_w_o_h  (busy16),
        .done_w_o_h  (done16),
        .result_w_o  (result16)
    );

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Launch one op on the 32-bit DUT and watch it to completion.
    // inj_k > 0 pulses a competing start in cycle T+inj_k.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int inj_k);
        int  done_at;
        bit  busy_ok;
        done_at = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) done_at = k;
            if (k == inj_k) begin
                funct3 = 3'b101; rs1 = 32'h5; rs2 = 32'h0; start = 1'b1;
            end
        end
        check({nm, " latency"}, 64'(done_at), 64'(lat));
        check({nm, " result"}, {32'h0, result}, {32'h0, exp});
        check({nm, " busy"}, {63'h0, busy_ok}, 64'h1);
        @(negedge clk);
        check({nm, " idle after"}, {62'h0, busy, done}, 64'h0);
    endtask

    vec_t vecs[$];

    initial begin
        int  done_at;
        bit  seen;

        vecs.push_back('{"MUL neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        vecs.push_back('{"MUL -1*-1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 34});
        vecs.push_back('{"MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{"MULH -1*-1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34});
        vecs.push_back('{"MULHU max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{"MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
        vecs.push_back('{"REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"DIV -7/-2", 3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34});
        vecs.push_back('{"REM -7/-2", 3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34});
        vecs.push_back('{"REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34});
        vecs.push_back('{"DIVU unsigned ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34});
        vecs.push_back('{"REMU unsigned ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF,
                         32'h8000_0000, 34});
        vecs.push_back('{"DIVU by 0", 3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF, 2});
        vecs.push_back('{"REM by 0", 3'b110, 32'h1234, 32'h0, 32'h1234, 2});
        vecs.push_back('{"DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
        vecs.push_back('{"REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2});

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset done", {63'h0, done}, 64'h0);
        check("reset result", {32'h0, result}, 64'h0);
        res_l = 1'b1;

        // 16-bit instance: MUL completes at T+18
        @(negedge clk);
        funct3_16 = 3'b000; rs1_16 = 16'd7; rs2_16 = 16'hFFFD; start16 = 1'b1;
        @(posedge clk);
        done_at = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16) done_at = k;
        end
        check("MUL16 latency", 64'(done_at), 64'd18);
        check("MUL16 result", {48'h0, result16}, 64'hFFEB);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
        end

        // Start while busy is ignored, original op finishes normally
        run_op("start ignored", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 5);

        // Abort at T+10 of a DIV
        @(negedge clk);
        funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", {63'h0, busy}, 64'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort no done", {63'h0, seen}, 64'h0);
        check("abort result kept", {32'h0, result}, 64'hFFFF_FFFE);

        // Reset held two cycles mid-CALC
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd9; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) res_l = 1'b0;
        end
        repeat (2) @(negedge clk);
        res_l = 1'b1;
        check("midreset busy", {63'h0, busy}, 64'h0);
        check("midreset done", {63'h0, done}, 64'h0);
        check("midreset result", {32'h0, result}, 64'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midreset no done", {63'h0, seen}, 64'h0);

        run_op("after reset", 3'b000, 32'd7, 32'd9, 32'd63, 34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
